// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_pkg
// Purpose  : Shared FSM state encoding and packet helpers for the adc capture path.
// Revision : 1.0
// ============================================================================
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_HDR_LO   = 3'd2,
    ST_HDR_HI   = 3'd3,
    ST_DATA     = 3'd4,
    ST_WAIT_LOW = 3'd5
  } state_t;

  localparam int HDR_WORDS = 2;

  // Index of the last data word in a packet: 2^min(lim,31) - 1.
  function automatic logic [63:0] last_word_index(input logic [7:0] lim);
    logic [4:0] lim_exp;
    lim_exp = (lim > 8'd31) ? 5'd31 : lim[4:0];
    return (64'd1 << lim_exp) - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_peak_detect.sv
`default_nettype none
// ============================================================================
// Module   : adc_peak_detect
// Purpose  : Signed running maximum with a level-sensitive clear.
// Revision : 1.0
// ============================================================================
module adc_peak_detect #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] value,
  output logic signed [WIDTH-1:0] peak
);

  localparam logic signed [WIDTH-1:0] MOST_NEGATIVE = {1'b1, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak <= MOST_NEGATIVE;
    end else if (clear) begin
      peak <= MOST_NEGATIVE;
    end else if (value > peak) begin
      peak <= value;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc.sv
`default_nettype none
// ============================================================================
// Module   : adc
// Purpose  : Dual-channel ADC sum, peak tracking and level-triggered packet streamer.
// Revision : 1.0
// ============================================================================
module adc
  import adc_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 14
) (
  input  logic        aclk,
  input  logic        areset,
  output logic        adc_csn,
  input  logic [15:0] adc_dat_a,
  input  logic [15:0] adc_dat_b,
  input  logic [7:0]  limiter,
  input  logic [15:0] trigger_level,
  input  logic        reset_trigger,
  input  logic        reset_max_sum,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic [15:0] cur_adc,
  output logic [63:0] cur_sample,
  output logic [15:0] max_sum_out,
  output logic [63:0] first_trigged,
  output logic [63:0] last_detrigged,
  output logic [63:0] cur_limiter,
  output logic [63:0] samples_sent,
  output logic        trigger_activated,
  output logic [15:0] triggers_count,
  output logic        dbg_send_first_trigged_high,
  output logic        dbg_trigger_now
);

  state_t      state;
  logic [15:0] ext_a;
  logic [15:0] ext_b;
  logic [15:0] samp_a;
  logic [15:0] samp_b;
  logic        trigger_now;
  logic        unused_bits;

  assign ext_a = {{(16-ADC_DATA_WIDTH){adc_dat_a[ADC_DATA_WIDTH-1]}}, adc_dat_a[ADC_DATA_WIDTH-1:0]};
  assign ext_b = {{(16-ADC_DATA_WIDTH){adc_dat_b[ADC_DATA_WIDTH-1]}}, adc_dat_b[ADC_DATA_WIDTH-1:0]};
  assign unused_bits = ^{adc_dat_a[15:ADC_DATA_WIDTH], adc_dat_b[15:ADC_DATA_WIDTH]};

  assign adc_csn           = 1'b1;
  assign trigger_now       = $signed(cur_adc) >= $signed(trigger_level);
  assign dbg_trigger_now   = trigger_now;
  assign trigger_activated = (state == ST_HDR_LO) || (state == ST_HDR_HI) ||
                             (state == ST_DATA)   || (state == ST_WAIT_LOW);

  // samp_a/samp_b stay aligned with cur_adc so a data beat carries the sample it was judged on.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cur_adc    <= 16'd0;
      samp_a     <= 16'd0;
      samp_b     <= 16'd0;
      cur_sample <= 64'd0;
    end else begin
      cur_adc    <= ext_a + ext_b;
      samp_a     <= ext_a;
      samp_b     <= ext_b;
      cur_sample <= cur_sample + 64'd1;
    end
  end

  adc_peak_detect #(.WIDTH(16)) u_peak (
    .clk   (aclk),
    .rst   (areset),
    .clear (reset_max_sum),
    .value (cur_adc),
    .peak  (max_sum_out)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state                       <= ST_IDLE;
      m_axis_tvalid               <= 1'b0;
      m_axis_tlast                <= 1'b0;
      m_axis_tdata                <= 32'd0;
      dbg_send_first_trigged_high <= 1'b0;
      first_trigged               <= 64'd0;
      last_detrigged              <= 64'd0;
      cur_limiter                 <= 64'd0;
      samples_sent                <= 64'd0;
      triggers_count              <= 16'd0;
    end else begin
      m_axis_tvalid               <= 1'b0;
      m_axis_tlast                <= 1'b0;
      dbg_send_first_trigged_high <= 1'b0;
      if (!reset_trigger) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            state          <= ST_ARMED;
            triggers_count <= 16'd0;
          end
          ST_ARMED: begin
            if (trigger_now) begin
              state         <= ST_HDR_LO;
              first_trigged <= cur_sample;
              cur_limiter   <= 64'd0;
              if (triggers_count != 16'hFFFF) triggers_count <= triggers_count + 16'd1;
            end
          end
          ST_HDR_LO: begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= first_trigged[31:0];
            samples_sent  <= samples_sent + 64'd1;
            state         <= ST_HDR_HI;
          end
          ST_HDR_HI: begin
            m_axis_tvalid               <= 1'b1;
            m_axis_tdata                <= first_trigged[63:32];
            dbg_send_first_trigged_high <= 1'b1;
            samples_sent                <= samples_sent + 64'd1;
            state                       <= ST_DATA;
          end
          ST_DATA: begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {samp_a, samp_b};
            samples_sent  <= samples_sent + 64'd1;
            cur_limiter   <= cur_limiter + 64'd1;
            // A detrigger on the final allowed word returns to ARMED, not WAIT_LOW.
            if (!trigger_now) begin
              m_axis_tlast   <= 1'b1;
              last_detrigged <= cur_sample;
              state          <= ST_ARMED;
            end else if (cur_limiter == last_word_index(limiter)) begin
              m_axis_tlast <= 1'b1;
              state        <= ST_WAIT_LOW;
            end
          end
          ST_WAIT_LOW: begin
            if (!trigger_now) begin
              last_detrigged <= cur_sample;
              state          <= ST_ARMED;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc
// Purpose  : Scoreboard bench for adc: directed stimulus, queued expected beats.
// Revision : 1.0
// ============================================================================
module tb_adc;

  logic        clk = 1'b0;
  logic        areset;
  logic        adc_csn;
  logic [15:0] adc_dat_a, adc_dat_b;
  logic [7:0]  limiter;
  logic [15:0] trigger_level;
  logic        reset_trigger, reset_max_sum;
  logic        m_axis_tvalid, m_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic [15:0] cur_adc, max_sum_out, triggers_count;
  logic [63:0] cur_sample, first_trigged, last_detrigged, cur_limiter, samples_sent;
  logic        trigger_activated, dbg_send_first_trigged_high, dbg_trigger_now;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        hi;
  } beat_t;

  beat_t       q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] cyc;
  logic [63:0] k;
  logic [63:0] z;
  logic [63:0] exp_beats;

  always #5 clk = ~clk;

  adc dut (
    .aclk                        (clk),
    .areset                      (areset),
    .adc_csn                     (adc_csn),
    .adc_dat_a                   (adc_dat_a),
    .adc_dat_b                   (adc_dat_b),
    .limiter                     (limiter),
    .trigger_level               (trigger_level),
    .reset_trigger               (reset_trigger),
    .reset_max_sum               (reset_max_sum),
    .m_axis_tvalid               (m_axis_tvalid),
    .m_axis_tlast                (m_axis_tlast),
    .m_axis_tdata                (m_axis_tdata),
    .cur_adc                     (cur_adc),
    .cur_sample                  (cur_sample),
    .max_sum_out                 (max_sum_out),
    .first_trigged               (first_trigged),
    .last_detrigged              (last_detrigged),
    .cur_limiter                 (cur_limiter),
    .samples_sent                (samples_sent),
    .trigger_activated           (trigger_activated),
    .triggers_count              (triggers_count),
    .dbg_send_first_trigged_high (dbg_send_first_trigged_high),
    .dbg_trigger_now             (dbg_trigger_now)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic last, input logic hi);
    beat_t b;
    b.data = d; b.last = last; b.hi = hi;
    q.push_back(b);
    exp_beats = exp_beats + 64'd1;
  endtask

  task automatic push_hdr(input logic [63:0] ts);
    push(ts[31:0], 1'b0, 1'b0);
    push(ts[63:32], 1'b0, 1'b1);
  endtask

  // Sample presented at edge number cyc (counted from reset release).
  task automatic tick(input logic [15:0] a, input logic [15:0] b);
    adc_dat_a = a;
    adc_dat_b = b;
    @(posedge clk);
    cyc = cyc + 64'd1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    beat_t e;
    if (!areset && m_axis_tvalid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_unexpected: got tdata %h tlast %b, expected no beat", m_axis_tdata, m_axis_tlast);
      end else begin
        e = q.pop_front();
        chk("beat_data", {32'd0, m_axis_tdata}, {32'd0, e.data});
        chk("beat_last", {63'd0, m_axis_tlast}, {63'd0, e.last});
        chk("beat_hdr_hi", {63'd0, dbg_send_first_trigged_high}, {63'd0, e.hi});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_beats     = 64'd0;
    areset        = 1'b1;
    adc_dat_a     = 16'd0;
    adc_dat_b     = 16'd0;
    limiter       = 8'd5;
    trigger_level = 16'd20;
    reset_trigger = 1'b0;
    reset_max_sum = 1'b0;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    cyc    = 64'd0;

    chk("rst_cur_adc", {48'd0, cur_adc}, 64'd0);
    chk("rst_cur_sample", cur_sample, 64'd0);
    chk("rst_max_sum", {48'd0, max_sum_out}, 64'h8000);
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_csn", {63'd0, adc_csn}, 64'd1);
    chk("rst_trig_act", {63'd0, trigger_activated}, 64'd0);

    // Two ramps, level 20: trigger on sum 20 (i=6), stream from i=9, tlast on the zero sample.
    reset_trigger = 1'b1;
    repeat (3) tick(16'd0, 16'd0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 38; i++) begin
        tick(16'(3 + i), 16'(5 + i));
        if (i == 6) begin k = cyc; push_hdr(k); end
        if (i >= 9) push({16'(3 + i), 16'(5 + i)}, 1'b0, 1'b0);
      end
      tick(16'd0, 16'd0);
      z = cyc;
      push(32'd0, 1'b1, 1'b0);
      repeat (2) tick(16'd0, 16'd0);
      chk("ramp_trig_count", {48'd0, triggers_count}, 64'(r + 1));
      chk("ramp_first_trig", first_trigged, k);
      chk("ramp_last_detrig", last_detrigged, z);
      chk("ramp_trig_act", {63'd0, trigger_activated}, 64'd0);
    end

    // limiter 1: two data words, then silence until the sum falls.
    limiter = 8'd1;
    for (int i = 0; i < 12; i++) begin
      tick(16'(100 + i), 16'd50);
      if (i == 0) push_hdr(cyc);
      if (i == 3) push({16'(103), 16'd50}, 1'b0, 1'b0);
      if (i == 4) push({16'(104), 16'd50}, 1'b1, 1'b0);
    end
    chk("lim_wait_act", {63'd0, trigger_activated}, 64'd1);
    chk("lim_cur_limiter", cur_limiter, 64'd2);
    tick(16'd0, 16'd0);
    z = cyc;
    repeat (2) tick(16'd0, 16'd0);
    chk("lim_last_detrig", last_detrigged, z);
    chk("lim_trig_act", {63'd0, trigger_activated}, 64'd0);
    chk("lim_trig_count", {48'd0, triggers_count}, 64'd3);

    // Negative sum vs level -20; upper input bits must be ignored.
    limiter = 8'd5;
    repeat (2) tick(16'h3FE0, 16'd0);
    trigger_level = 16'hFFEC;
    repeat (2) tick(16'h3FE0, 16'd0);
    for (int n = 0; n < 6; n++) begin
      tick(16'h7FF0, 16'h8000);
      if (n == 0) push_hdr(cyc);
      if (n >= 3) push(32'hFFF0_0000, 1'b0, 1'b0);
    end
    chk("neg_cur_adc", {48'd0, cur_adc}, 64'hFFF0);
    chk("neg_trig_now", {63'd0, dbg_trigger_now}, 64'd1);
    tick(16'h3FE0, 16'd0);
    push(32'hFFE0_0000, 1'b1, 1'b0);
    chk("neg_trig_now_low", {63'd0, dbg_trigger_now}, 64'd0);
    repeat (2) tick(16'h3FE0, 16'd0);
    trigger_level = 16'd20;
    repeat (2) tick(16'd0, 16'd0);

    // Peak detector: 10, 50, 30 -> 50; clear; then 7.
    reset_trigger = 1'b0;
    reset_max_sum = 1'b1;
    tick(16'd0, 16'd0);
    chk("peak_clear0", {48'd0, max_sum_out}, 64'h8000);
    reset_max_sum = 1'b0;
    tick(16'd4, 16'd6);
    tick(16'd20, 16'd30);
    tick(16'd10, 16'd20);
    repeat (2) tick(16'd0, 16'd0);
    chk("peak_50", {48'd0, max_sum_out}, 64'd50);
    reset_max_sum = 1'b1;
    tick(16'd0, 16'd0);
    chk("peak_clear1", {48'd0, max_sum_out}, 64'h8000);
    reset_max_sum = 1'b0;
    tick(16'd3, 16'd4);
    repeat (2) tick(16'd0, 16'd0);
    chk("peak_7", {48'd0, max_sum_out}, 64'd7);

    // Abort mid-DATA by disarming; re-arm clears the event count.
    reset_trigger = 1'b1;
    repeat (2) tick(16'd0, 16'd0);
    chk("arm_count_clear", {48'd0, triggers_count}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 6) reset_trigger = 1'b0;
      tick(16'(200 + i), 16'd0);
      if (i == 0) push_hdr(cyc);
      if (i == 3 || i == 4) push({16'(200 + i), 16'd0}, 1'b0, 1'b0);
      if (i == 6) begin
        chk("abort_trig_act", {63'd0, trigger_activated}, 64'd0);
        chk("abort_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      end
    end
    tick(16'd0, 16'd0);
    chk("abort_count_held", {48'd0, triggers_count}, 64'd1);
    reset_trigger = 1'b1;
    tick(16'd0, 16'd0);
    chk("rearm_count_clear", {48'd0, triggers_count}, 64'd0);
    repeat (2) tick(16'd0, 16'd0);
    chk("samples_sent", samples_sent, exp_beats);
    chk("cur_sample", cur_sample, cyc);

    // Asynchronous reset in the middle of a packet.
    for (int i = 0; i < 5; i++) begin
      tick(16'd100, 16'd100);
      if (i == 0) push_hdr(cyc);
      if (i == 3) push({16'd100, 16'd100}, 1'b0, 1'b0);
    end
    #2 areset = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("mid_rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    chk("mid_rst_cur_adc", {48'd0, cur_adc}, 64'd0);
    chk("mid_rst_cur_sample", cur_sample, 64'd0);
    chk("mid_rst_max", {48'd0, max_sum_out}, 64'h8000);
    chk("mid_rst_first", first_trigged, 64'd0);
    chk("mid_rst_last", last_detrigged, 64'd0);
    chk("mid_rst_limiter", cur_limiter, 64'd0);
    chk("mid_rst_sent", samples_sent, 64'd0);
    chk("mid_rst_count", {48'd0, triggers_count}, 64'd0);
    chk("mid_rst_act", {63'd0, trigger_activated}, 64'd0);
    chk("mid_rst_csn", {63'd0, adc_csn}, 64'd1);
    @(negedge clk);
    areset = 1'b0;
    repeat (2) @(negedge clk);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc.md
# adc

Front-end capture block between the dual-channel 14-bit ADC and the AXI-Stream DMA path. It sums the two channels every clock and tracks the peak of that sum. It detects level-trigger events on the sum and emits one framed packet per event on a 32-bit master stream. Each packet is a 64-bit timestamp header followed by raw sample words, length-limited by `limiter`.

## Interface
- `ADC_DATA_WIDTH`, 14: significant two's-complement bits in `adc_dat_a/b[ADC_DATA_WIDTH-1:0]`; upper bits ignored.
- `aclk` in 1: single clock; all logic rising-edge.
- `areset` in 1: reset, asynchronous, active-high; clears every register.
- `adc_csn` out 1: ADC chip select; constant 1.
- `adc_dat_a`, `adc_dat_b` in 16: raw channel samples.
- `limiter` in 8: maximum data words per packet = 2^min(limiter,31).
- `trigger_level` in 16: signed threshold on the channel sum.
- `reset_trigger` in 1: level; 0 = disarmed/cleared, 1 = armed.
- `reset_max_sum` in 1: level; 1 holds peak detector cleared.
- `m_axis_tvalid`, `m_axis_tlast` out 1, `m_axis_tdata` out 32: master stream; no tready, so the sink must always accept.
- `cur_adc` out 16: registered signed sum.
- `cur_sample` out 64: free-running sample counter.
- `max_sum_out` out 16 signed: peak sum.
- `first_trigged`, `last_detrigged` out 64: cur_sample at latest trigger / detrigger.
- `cur_limiter` out 64: data words in current packet.
- `samples_sent` out 64: total stream beats.
- `trigger_activated` out 1: in-event flag.
- `triggers_count` out 16: events since arming.
- `dbg_send_first_trigged_high` out 1: high while header high word is driven.
- `dbg_trigger_now` out 1: combinational `cur_adc >= trigger_level`.

## Operation
- Each cycle: `a`,`b` = sign-extended `[ADC_DATA_WIDTH-1:0]` to 16 bits; `cur_adc <= a+b` (16-bit, wrap on overflow); `cur_sample++` (wraps at 2^64).
- Peak: if `reset_max_sum` then `max_sum_out <= 16'h8000`, else `max_sum_out <= max(max_sum_out, cur_adc)` (signed).
- Comparison `cur_adc >= trigger_level` is signed.
- FSM states: IDLE, ARMED, HDR_LO, HDR_HI, DATA, WAIT_LOW.
  - IDLE: entered on reset or while `reset_trigger=0`, from any state.
  - IDLE → ARMED when `reset_trigger=1`; `triggers_count` is cleared on that entry.
  - ARMED → HDR_LO when the comparison is true. On the same edge: `first_trigged <= cur_sample`, `triggers_count++` (saturating), `cur_limiter <= 0`.
  - HDR_LO: emit `first_trigged[31:0]`, then go to HDR_HI.
  - HDR_HI: emit `first_trigged[63:32]` with the dbg flag set, then go to DATA.
  - DATA: emit `{a,b}` of the current sample each cycle, `cur_limiter++`.
    - If the sum is below level: that beat has tlast=1, `last_detrigged <= cur_sample`, go to ARMED.
    - Else if `cur_limiter == 2^limiter-1`: that beat has tlast=1, go to WAIT_LOW.
    - Both conditions in the same cycle: the detrigger path wins.
  - WAIT_LOW: no output; when the sum drops below level, latch `last_detrigged` and go to ARMED.
- Samples arriving during header beats are not streamed.
- `trigger_activated` = state ∈ {HDR_LO, HDR_HI, DATA, WAIT_LOW}.
- `samples_sent` increments on every valid beat, headers included.
- Deasserting `reset_trigger` mid-packet aborts the packet with no tlast.

## Timing
- Reset values: all counters/registers 0, `max_sum_out` 16'h8000, state IDLE, `adc_csn` 1, tvalid/tlast 0.
- Sample present at edge k appears in `cur_adc` after edge k. Its trigger decision is made at edge k+1. Its stream beat (DATA) is driven after edge k+1.
- Header low beat follows the trigger edge by 1 cycle; first data beat follows by 3.
- tvalid is high for exactly one cycle per beat; beats are back-to-back within a packet.

## Structure
- Shared package: FSM state enum and header word count (2).
- Natural sub-module: `adc_peak_detect` (signed running max with clear).

## Test plan
- Reset: assert `areset` mid-packet → all outputs at reset values, no tvalid.
- Ramp a:3..40, b:5..42, level 20, limiter 5, armed → header (first_trigged lo/hi), data beats until sum<20, last beat tlast=1, triggers_count increments per ramp.
- limiter 1, long over-threshold input → header + exactly 2 data beats, second tlast=1, no further beats until the sum drops.
- Negative inputs (a=14'h3FF0, b=0) vs level −20 → trigger fires; sum sign-extended correctly.
- Peak: sums 10,50,30 → `max_sum_out`=50; pulse `reset_max_sum` → 16'h8000 then tracks again.
- `reset_trigger` 1→0 during DATA → stream stops immediately, `trigger_activated`=0, counts cleared on re-arm.
